// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin hold arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface rr_hold_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output preempt
  );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter: an owner keeps the grant while it requests,
// but is pre-empted after MAX_HOLD cycles whenever another requester is waiting.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N),
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             reset,
  rr_hold_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

  state_t         state;
  logic [IDW-1:0] last;
  logic [CW-1:0]  hold_cnt;
  logic [N-1:0]   gnt_q;
  logic           gnt_valid_q;
  logic [IDW-1:0] gnt_id_q;
  logic           preempt_q;

  logic [IDW-1:0] cand;
  logic           any_req;
  logic           others_pending;
  logic           owner_req;
  logic [N-1:0]   owner_mask;

  // Scan from last+1 upward with wrap; the previous owner is checked last,
  // so any other pending requester always wins over it.
  always_comb begin
    cand = last;
    for (int i = N; i >= 1; i--) begin
      if (bus.req[(int'(last) + i) % N]) begin
        cand = IDW'((int'(last) + i) % N);
      end
    end
  end

  always_comb begin
    owner_mask     = N'(1) << last;
    any_req        = |bus.req;
    owner_req      = |(bus.req & owner_mask);
    others_pending = |(bus.req & ~owner_mask);
  end

  // Single state machine; every output is a register updated on the same edge
  // as the ownership change, so gnt, gnt_id and gnt_valid never skew.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= LAST_INIT;
      hold_cnt    <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= OWNED;
            last        <= cand;
            hold_cnt    <= '0;
            gnt_q       <= N'(1) << cand;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= cand;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            if (any_req) begin
              last     <= cand;
              hold_cnt <= '0;
              gnt_q    <= N'(1) << cand;
              gnt_id_q <= cand;
            end else begin
              state       <= IDLE;
              hold_cnt    <= '0;
              gnt_q       <= '0;
              gnt_valid_q <= 1'b0;
              gnt_id_q    <= '0;
            end
          end else if (hold_cnt < HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else if (others_pending) begin
            last      <= cand;
            hold_cnt  <= '0;
            gnt_q     <= N'(1) << cand;
            gnt_id_q  <= cand;
            preempt_q <= 1'b1;
          end else begin
            hold_cnt <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          hold_cnt    <= '0;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
          gnt_id_q    <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: directed scenarios plus random request traffic,
// scored against a cycle-level ownership model through an expectation queue.
module tb_rr_hold_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rr_hold_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           preempt;
    string          tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: owner index (-1 when idle), last owner, cycles served so far.
  int   m_owner;
  int   m_last;
  int   m_served;
  logic m_pre;

  function automatic int pick(int from, logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      if (r[(from + i) % N]) return (from + i) % N;
    end
    return -1;
  endfunction

  function void model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_served = 0;
    m_pre    = 1'b0;
  endfunction

  function void model_step(logic [N-1:0] r);
    logic [N-1:0] others;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner  = pick(m_last, r);
        m_served = 1;
      end
    end else if (!r[m_owner]) begin
      if (r != 0) begin
        m_owner  = pick(m_last, r);
        m_served = 1;
      end else begin
        m_owner = -1;
      end
    end else if (m_served < MAX_HOLD) begin
      m_served++;
    end else begin
      others = r & ~(N'(1) << m_owner);
      if (others != 0) begin
        m_owner  = pick(m_owner, r);
        m_pre    = 1'b1;
      end
      m_served = 1;
    end
    if (m_owner >= 0) m_last = m_owner;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests and queue what the model says the next edge yields.
  task automatic applyStimulus(input logic [N-1:0] r, input string tag);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    model_step(r);
    e.gnt       = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.gnt_valid = (m_owner >= 0);
    e.gnt_id    = (m_owner >= 0) ? IDW'(m_owner) : '0;
    e.preempt   = m_pre;
    e.tag       = tag;
    sb.push_back(e);
  endtask

  task automatic pulse_reset(input bit check_now);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    if (check_now) begin
      checkOutput("async_reset_gnt", 32'(bus.gnt), 32'd0);
      checkOutput("async_reset_valid", 32'(bus.gnt_valid), 32'd0);
      checkOutput("async_reset_id", 32'(bus.gnt_id), 32'd0);
      checkOutput("async_reset_preempt", 32'(bus.preempt), 32'd0);
    end
    bus.req = '0;
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, "_gnt"}, 32'(bus.gnt), 32'(e.gnt));
        checkOutput({e.tag, "_valid"}, 32'(bus.gnt_valid), 32'(e.gnt_valid));
        checkOutput({e.tag, "_id"}, 32'(bus.gnt_id), 32'(e.gnt_id));
        checkOutput({e.tag, "_preempt"}, 32'(bus.preempt), 32'(e.preempt));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, queue depth %0d", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] r;
    reset   = 1'b1;
    bus.req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("reset_valid", 32'(bus.gnt_valid), 32'd0);
    checkOutput("reset_id", 32'(bus.gnt_id), 32'd0);
    checkOutput("reset_preempt", 32'(bus.preempt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] idle");
    repeat (10) applyStimulus(4'b0000, "idle");

    $display("[TB] single owner");
    repeat (10) applyStimulus(4'b0100, "single");
    repeat (3) applyStimulus(4'b0000, "single_rel");

    $display("[TB] full contention");
    pulse_reset(1'b0);
    repeat (20) applyStimulus(4'b1111, "contend");

    $display("[TB] early release and rotation");
    pulse_reset(1'b0);
    repeat (2) applyStimulus(4'b0011, "early");
    repeat (3) applyStimulus(4'b0010, "early_next");
    applyStimulus(4'b0000, "rot_idle");
    repeat (3) applyStimulus(4'b1011, "rotate");

    $display("[TB] async reset mid-grant");
    pulse_reset(1'b0);
    repeat (3) applyStimulus(4'b1000, "pre_reset");
    pulse_reset(1'b1);
    repeat (6) applyStimulus(4'b1111, "post_reset");

    $display("[TB] random traffic");
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      if (c == 200) begin
        pulse_reset(1'b1);
      end
      applyStimulus(r, "random");
    end
    applyStimulus(4'b0000, "drain");

    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Registered round-robin arbiter that shares one resource between N requesters. A grant is held while the owner keeps its request asserted, up to a bounded hold time. After that limit the grant is pre-empted in favour of the next pending requester. It replaces the fixed two-requester arbiter in front of shared datapath resources and generalises it to N ports with fairness and starvation bounds.

## Interface
- N, default 4, number of requesters (2..16).
- MAX_HOLD, default 8, maximum consecutive granted cycles before pre-emption when another requester is pending (≥1).
- IDW, default $clog2(N), width of gnt_id.
- CW, default $clog2(MAX_HOLD+1), width of the internal hold counter.
- clk input 1: rising-edge clock.
- reset input 1: asynchronous, active-high reset. Same clock domain as all other ports.
- req input N: request per requester, level-sensitive, sampled on clk rising edge.
- gnt output N: registered one-hot grant (all zero when idle).
- gnt_valid output 1: registered, equals |gnt.
- gnt_id output IDW: registered binary index of the granted requester; 0 when idle.
- preempt output 1: registered one-cycle pulse, high during the first cycle of a grant that was forced by hold expiry.

## Operation
- State: IDLE (no grant) or OWNED (one requester granted). Internal registers:
  - last: index of the most recent owner; reset value N-1, so requester 0 has first priority.
  - hold_cnt: number of granted cycles already served.
- Candidate selection: the first requester with req set, searching last+1, last+2, …, wrapping modulo N. The current owner is the last one checked.
- IDLE:
  - If req≠0, grant the candidate: go to OWNED, hold_cnt=0, last=candidate, preempt=0.
  - Else stay in IDLE.
- OWNED, owner is k:
  - req[k]=0 (release):
    - If another requester is pending, grant the candidate in the same edge, with no bubble. hold_cnt=0, preempt=0.
    - Else go to IDLE and clear gnt.
  - req[k]=1 and hold_cnt<MAX_HOLD-1: keep the grant, hold_cnt+1.
  - req[k]=1, hold_cnt==MAX_HOLD-1, another requester pending: switch to the candidate (≠k), hold_cnt=0, preempt=1 for one cycle.
  - req[k]=1, hold_cnt==MAX_HOLD-1, no other requester: keep the grant, hold_cnt=0, preempt=0.
- Starvation bound: a continuously requesting port is granted within (N-1)·MAX_HOLD cycles.
- Exactly one gnt bit is high when gnt_valid=1. gnt, gnt_id and gnt_valid always change on the same edge.
- Requests may drop without a grant. An unserved request that drops is simply forgotten.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - Internal: state=IDLE, last=N-1, hold_cnt=0.
- Reset asserted mid-grant: gnt drops without waiting for clk.
- After reset deasserts: first arbitration on the first clk edge with reset low.
- Latency:
  - req set before edge E from IDLE: gnt visible after E, i.e. one cycle.
  - Owner drops req before edge E: gnt[k] clears at E. The next owner, if any, is granted at the same E.
- Maximum continuous grant with others pending: exactly MAX_HOLD cycles.
- preempt is high for exactly one cycle, aligned with the new owner's first grant cycle.

## Test plan
N=4, MAX_HOLD=4.

- **Idle:** req=0000 for 10 cycles → gnt=0000, gnt_valid=0, gnt_id=0, preempt=0 throughout.
- **Single owner:** req=0100 held 10 cycles, then 0000 → gnt=0100, gnt_id=2 from the cycle after req rises. Held all 10 cycles, preempt never set. gnt=0000 one cycle after req drops.
- **Full contention:** req=1111 held 20 cycles from reset → gnt sequence 0001, 0010, 0100, 1000, 0001, each for exactly 4 cycles. preempt pulses on every switch after the first grant.
- **Early release, no bubble:** req=0011, owner 0 drops req[0] after 2 granted cycles → gnt goes 0001→0010 on the same edge, gnt_valid never 0, preempt=0.
- **Rotation from last:** after requester 1 owns and releases, req=1011 → next grant is requester 3, not 0.
- **Async reset mid-grant:** reset pulsed between clock edges while gnt=1000 → gnt=0000 immediately. After release, req=1111 grants requester 0 first.
